// File: rtl/rob_pkg.sv
// Reorder buffer shared types: opcode constants, widths and entry record.
// Imported by the interface, the commit selector and the top.
package rob_pkg;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 32;
   localparam int REG_POS_W = 5;

   localparam logic [6:0] OPCODE_S    = 7'b0100011;
   localparam logic [6:0] OPCODE_BR   = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR = 7'b1100111;

   typedef struct packed {
      logic                 ready;
      logic [REG_POS_W-1:0] rd;
      logic [6:0]           opcode;
      logic [ADDR_W-1:0]    pc;
      logic                 pred_jump;
      logic                 res_jump;
      logic [ADDR_W-1:0]    res_pc;
      logic [DATA_W-1:0]    val;
   } rob_entry_t;

   // Branch or JALR: can redirect fetch on retirement.
   function automatic logic is_ctrl(input logic [6:0] op);
      return (op == OPCODE_BR) || (op == OPCODE_JALR);
   endfunction

   // Instructions that must retire alone in slot 0 (single store/branch port).
   function automatic logic is_serial(input logic [6:0] op);
      return (op == OPCODE_S) || is_ctrl(op);
   endfunction

endpackage

// File: rtl/rob_multi_commit_if.sv
// Bundle between the ROB and its neighbours: issue, writeback, operand query, commit.
// master = surrounding pipeline (drives issue/wb/query), slave = ROB.
interface rob_multi_commit_if #(
   parameter int DEPTH    = 16,
   parameter int COMMIT_W = 2,
   parameter int NUM_WB   = 2
);
   import rob_pkg::*;
   localparam int PW = $clog2(DEPTH);

   logic                          issue;
   logic [REG_POS_W-1:0]          issue_rd;
   logic [6:0]                    issue_opcode;
   logic [ADDR_W-1:0]             issue_pc;
   logic                          issue_pred_jump;
   logic                          issue_is_ready;
   logic                          rob_nxt_full;
   logic [PW:0]                   count;
   logic [PW-1:0]                 nxt_rob_pos;
   logic [PW-1:0]                 head_rob_pos;

   logic [NUM_WB-1:0]             wb_valid;
   logic [NUM_WB*PW-1:0]          wb_rob_pos;
   logic [NUM_WB*DATA_W-1:0]      wb_val;
   logic                          wb_jump;
   logic [ADDR_W-1:0]             wb_pc;

   logic [PW-1:0]                 rs1_pos;
   logic [PW-1:0]                 rs2_pos;
   logic                          rs1_ready;
   logic                          rs2_ready;
   logic [DATA_W-1:0]             rs1_val;
   logic [DATA_W-1:0]             rs2_val;

   logic [COMMIT_W-1:0]           reg_write;
   logic [COMMIT_W*REG_POS_W-1:0] reg_rd;
   logic [COMMIT_W*DATA_W-1:0]    reg_val;
   logic [PW-1:0]                 commit_rob_pos;
   logic                          lsb_store;
   logic                          commit_br;
   logic                          commit_br_jump;
   logic [ADDR_W-1:0]             commit_br_pc;
   logic                          rollback;
   logic                          if_set_pc_en;
   logic [ADDR_W-1:0]             if_set_pc;

   modport master (
      output issue, issue_rd, issue_opcode, issue_pc,
      output issue_pred_jump, issue_is_ready,
      output wb_valid, wb_rob_pos, wb_val, wb_jump, wb_pc,
      output rs1_pos, rs2_pos,
      input  rob_nxt_full, count, nxt_rob_pos, head_rob_pos,
      input  rs1_ready, rs2_ready, rs1_val, rs2_val,
      input  reg_write, reg_rd, reg_val, commit_rob_pos,
      input  lsb_store, commit_br, commit_br_jump, commit_br_pc,
      input  rollback, if_set_pc_en, if_set_pc
   );

   modport slave (
      input  issue, issue_rd, issue_opcode, issue_pc,
      input  issue_pred_jump, issue_is_ready,
      input  wb_valid, wb_rob_pos, wb_val, wb_jump, wb_pc,
      input  rs1_pos, rs2_pos,
      output rob_nxt_full, count, nxt_rob_pos, head_rob_pos,
      output rs1_ready, rs2_ready, rs1_val, rs2_val,
      output reg_write, reg_rd, reg_val, commit_rob_pos,
      output lsb_store, commit_br, commit_br_jump, commit_br_pc,
      output rollback, if_set_pc_en, if_set_pc
   );

endinterface

// File: rtl/rob_commit_sel.sv
// Retirement eligibility for slot 0/1 and misprediction detection at head.
// In: enable, occupancy, head/head+1 status. Out: commit0/1, mispred, ncommit.
module rob_commit_sel
   import rob_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int COMMIT_W = 2
) (
   input  logic                     en,
   input  logic [$clog2(DEPTH):0]   count,
   input  logic                     ready0,
   input  logic [6:0]               op0,
   input  logic                     pred0,
   input  logic                     jump0,
   input  logic                     ready1,
   input  logic [6:0]               op1,
   output logic                     commit0,
   output logic                     commit1,
   output logic                     mispred,
   output logic [1:0]               ncommit
);
   localparam int PW = $clog2(DEPTH);

   always_comb begin
      commit0 = en && (count != '0) && ready0;
      mispred = commit0 && is_ctrl(op0) && (pred0 != jump0);
      commit1 = 1'b0;
      if (COMMIT_W > 1) begin
         // Store/branch/JALR own the single side port, so they retire alone.
         commit1 = commit0 && (count >= (PW+1)'(2)) && ready1 &&
                   !is_serial(op0) && !is_serial(op1);
      end
      ncommit = {1'b0, commit0} + {1'b0, commit1};
   end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer with multi-slot in-order commit, NUM_WB writeback channels,
// operand bypass query and misprediction rollback. Ports: clk, rst (async low), rdy, bus.
module rob_multi_commit #(
   parameter int DEPTH    = 16,
   parameter int COMMIT_W = 2,
   parameter int NUM_WB   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   rob_multi_commit_if.slave  bus
);
   import rob_pkg::*;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 2;
   localparam int RW = REG_POS_W;

   rob_entry_t ent_q [DEPTH];
   rob_entry_t ent_d [DEPTH];

   logic [PW-1:0]             head_q, head_d;
   logic [PW-1:0]             tail_q, tail_d;
   logic [PW-1:0]             head1;
   logic [PW:0]               count_q, count_d;
   logic [COMMIT_W-1:0]       reg_write_q, reg_write_d;
   logic [COMMIT_W*RW-1:0]    reg_rd_q, reg_rd_d;
   logic [COMMIT_W*DATA_W-1:0] reg_val_q, reg_val_d;
   logic [PW-1:0]             commit_pos_q, commit_pos_d;
   logic                      lsb_store_q, lsb_store_d;
   logic                      br_q, br_d;
   logic                      br_jump_q, br_jump_d;
   logic [ADDR_W-1:0]         br_pc_q, br_pc_d;
   logic                      rollback_q, rollback_d;
   logic                      set_pc_en_q, set_pc_en_d;
   logic [ADDR_W-1:0]         set_pc_q, set_pc_d;

   logic                      commit0, commit1, mispred, issue_ok;
   logic [1:0]                ncommit;
   logic [CW-1:0]             nxt_cnt;

   assign head1 = head_q + PW'(1);

   rob_commit_sel #(
      .DEPTH    (DEPTH),
      .COMMIT_W (COMMIT_W)
   ) u_sel (
      .en      (!rollback_q),
      .count   (count_q),
      .ready0  (ent_q[head_q].ready),
      .op0     (ent_q[head_q].opcode),
      .pred0   (ent_q[head_q].pred_jump),
      .jump0   (ent_q[head_q].res_jump),
      .ready1  (ent_q[head1].ready),
      .op1     (ent_q[head1].opcode),
      .commit0 (commit0),
      .commit1 (commit1),
      .mispred (mispred),
      .ncommit (ncommit)
   );

   assign nxt_cnt = {1'b0, count_q} + CW'(bus.issue) - CW'(ncommit);
   assign bus.rob_nxt_full = (nxt_cnt == CW'(DEPTH));

   always_comb begin
      ent_d        = ent_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      reg_write_d  = '0;
      reg_rd_d     = '0;
      reg_val_d    = '0;
      commit_pos_d = head_q;
      lsb_store_d  = 1'b0;
      br_d         = 1'b0;
      br_jump_d    = 1'b0;
      br_pc_d      = '0;
      rollback_d   = 1'b0;
      set_pc_en_d  = 1'b0;
      set_pc_d     = '0;
      issue_ok     = bus.issue && (count_q != (PW+1)'(DEPTH));

      if (issue_ok) begin
         ent_d[tail_q]           = '0;
         ent_d[tail_q].ready     = bus.issue_is_ready;
         ent_d[tail_q].rd        = bus.issue_rd;
         ent_d[tail_q].opcode    = bus.issue_opcode;
         ent_d[tail_q].pc        = bus.issue_pc;
         ent_d[tail_q].pred_jump = bus.issue_pred_jump;
         tail_d                  = tail_q + PW'(1);
      end

      if (commit0) begin
         ent_d[head_q].ready = 1'b0;
         unique case (1'b1)
            ent_q[head_q].opcode == OPCODE_S: lsb_store_d = 1'b1;
            ent_q[head_q].opcode == OPCODE_BR: begin
               br_d      = 1'b1;
               br_jump_d = ent_q[head_q].res_jump;
               br_pc_d   = ent_q[head_q].pc;
            end
            default: begin
               reg_write_d[0]      = 1'b1;
               reg_rd_d[RW-1:0]    = ent_q[head_q].rd;
               reg_val_d[DATA_W-1:0] = ent_q[head_q].val;
            end
         endcase
         if (mispred) begin
            rollback_d  = 1'b1;
            set_pc_en_d = 1'b1;
            set_pc_d    = ent_q[head_q].res_pc;
         end
      end

      // commit1 is constant 0 when COMMIT_W == 1, so the top slot index is safe.
      if (commit1) begin
         ent_d[head1].ready = 1'b0;
         reg_write_d[COMMIT_W-1] = 1'b1;
         reg_rd_d[(COMMIT_W-1)*RW +: RW] = ent_q[head1].rd;
         reg_val_d[(COMMIT_W-1)*DATA_W +: DATA_W] = ent_q[head1].val;
      end

      // Ascending order: higher channel wins a same-entry collision.
      for (int c = 0; c < NUM_WB; c++) begin
         if (bus.wb_valid[c]) begin
            ent_d[bus.wb_rob_pos[c*PW +: PW]].ready = 1'b1;
            ent_d[bus.wb_rob_pos[c*PW +: PW]].val =
               bus.wb_val[c*DATA_W +: DATA_W];
            if (c == 0) begin
               ent_d[bus.wb_rob_pos[PW-1:0]].res_jump = bus.wb_jump;
               ent_d[bus.wb_rob_pos[PW-1:0]].res_pc   = bus.wb_pc;
            end
         end
      end

      head_d  = head_q + PW'(ncommit);
      count_d = count_q + (PW+1)'(issue_ok) - (PW+1)'(ncommit);

      // Cycle after a mispredict: drop everything, including this cycle's inputs.
      if (rollback_q) begin
         ent_d        = '{default: '0};
         head_d       = '0;
         tail_d       = '0;
         count_d      = '0;
         commit_pos_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent_q        <= '{default: '0};
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         reg_write_q  <= '0;
         reg_rd_q     <= '0;
         reg_val_q    <= '0;
         commit_pos_q <= '0;
         lsb_store_q  <= 1'b0;
         br_q         <= 1'b0;
         br_jump_q    <= 1'b0;
         br_pc_q      <= '0;
         rollback_q   <= 1'b0;
         set_pc_en_q  <= 1'b0;
         set_pc_q     <= '0;
      end else if (rdy) begin
         ent_q        <= ent_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         reg_write_q  <= reg_write_d;
         reg_rd_q     <= reg_rd_d;
         reg_val_q    <= reg_val_d;
         commit_pos_q <= commit_pos_d;
         lsb_store_q  <= lsb_store_d;
         br_q         <= br_d;
         br_jump_q    <= br_jump_d;
         br_pc_q      <= br_pc_d;
         rollback_q   <= rollback_d;
         set_pc_en_q  <= set_pc_en_d;
         set_pc_q     <= set_pc_d;
      end
   end

   // Operand query: registered state plus same-cycle writeback bypass.
   always_comb begin
      bus.rs1_ready = ent_q[bus.rs1_pos].ready;
      bus.rs1_val   = ent_q[bus.rs1_pos].val;
      bus.rs2_ready = ent_q[bus.rs2_pos].ready;
      bus.rs2_val   = ent_q[bus.rs2_pos].val;
      for (int c = 0; c < NUM_WB; c++) begin
         if (bus.wb_valid[c] && bus.wb_rob_pos[c*PW +: PW] == bus.rs1_pos) begin
            bus.rs1_ready = 1'b1;
            bus.rs1_val   = bus.wb_val[c*DATA_W +: DATA_W];
         end
         if (bus.wb_valid[c] && bus.wb_rob_pos[c*PW +: PW] == bus.rs2_pos) begin
            bus.rs2_ready = 1'b1;
            bus.rs2_val   = bus.wb_val[c*DATA_W +: DATA_W];
         end
      end
   end

   assign bus.count          = count_q;
   assign bus.nxt_rob_pos    = tail_q;
   assign bus.head_rob_pos   = head_q;
   assign bus.reg_write      = reg_write_q;
   assign bus.reg_rd         = reg_rd_q;
   assign bus.reg_val        = reg_val_q;
   assign bus.commit_rob_pos = commit_pos_q;
   assign bus.lsb_store      = lsb_store_q;
   assign bus.commit_br      = br_q;
   assign bus.commit_br_jump = br_jump_q;
   assign bus.commit_br_pc   = br_pc_q;
   assign bus.rollback       = rollback_q;
   assign bus.if_set_pc_en   = set_pc_en_q;
   assign bus.if_set_pc      = set_pc_q;

endmodule
